fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

FIFO control unit that turns push/pop requests into addresses and a write enable for the 2^W-entry register file, forming a synchronous FIFO with it. It owns the write and read pointers, full/empty/occupancy status, and sticky error flags. Its `w_addr`, `r_addr` and `wr_en` outputs connect directly to the register file's ports of the same name. The head entry is read combinationally through `r_addr`.

## Interface
- `W`, 2: address width; FIFO depth is 2^W entries (default 4).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr`  in  1  push request; data is already on the register file's `w_data`.
- `rd`  in  1  pop request; removes the head entry.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `wr_en`  out  1  register-file write enable; combinational, equals `wr & ~full`.
- `w_addr`  out  W  write pointer; the next free slot.
- `r_addr`  out  W  read pointer; the head slot.
- `full`  out  1  registered; high when the FIFO holds 2^W entries.
- `empty`  out  1  registered; high when the FIFO holds 0 entries.
- `count`  out  W+1  registered occupancy, 0 to 2^W.
- `ovf`  out  1  sticky; set by a push attempted while `full` is high and the push is not accepted.
- `udf`  out  1  sticky; set by a pop attempted while `empty` is high.

## Operation
- Accepted push = `wr & ~full`, or `wr & rd & full` (see the simultaneous rule below). On an accepted push, `w_addr` increments modulo 2^W.
- Accepted pop = `rd & ~empty`. On an accepted pop, `r_addr` increments modulo 2^W.
- Pointer wrap: from 2^W-1 to 0 with no extra state; full and empty are distinguished by the registered flags, not by pointer comparison alone.
- Simultaneous push and pop:
  - Not empty and not full: both pointers advance; `count`, `full` and `empty` are unchanged.
  - Empty: push only. `rd` is ignored, `udf` is set, `empty` drops, `count` becomes 1.
  - Full: both pointers advance and `wr_en` is forced high. The head is read this cycle and overwritten at the edge. `full` stays high and `ovf` is not set.
- Flag update on a push-only cycle: `empty` goes to 0. `full` goes to 1 when the next `w_addr` equals `r_addr`.
- Flag update on a pop-only cycle: `full` goes to 0. `empty` goes to 1 when the next `r_addr` equals `w_addr`.
- `count`: +1 on push-only, -1 on pop-only, unchanged otherwise. It never exceeds 2^W or drops below 0.
- Error flags: `ovf` and `udf` hold until `clr_err` is asserted. If `clr_err` coincides with a new error, the set wins.

## Timing
- Reset values (asynchronous, while `reset_n` = 0): `w_addr`=0, `r_addr`=0, `empty`=1, `full`=0, `count`=0, `ovf`=0, `udf`=0. `wr_en` then follows its equation (`wr` while empty).
- Reset asserted mid-operation discards all contents immediately; no cycle is needed. After deassertion, the first rising edge processes requests normally.
- Write latency: data pushed at edge N is visible on the register file's `r_data` after edge N when it is the head. First-word fall-through, 0 added cycles.
- Pop latency: `r_addr` advances at the edge that accepts the pop. The next entry appears on `r_data` combinationally after that edge.
- Status: `full`, `empty` and `count` reflect all requests accepted up to and including the last edge. There are no combinational paths from `rd`/`wr` to the status outputs.
- `wr_en` is the only combinational output. It must settle before the same rising edge used by the register file.

## Structure
- Shared header `fifo_defs.vh`: the default `W`, the derived depth `2**W`, and a localparam for the `count` width (W+1). The testbench and the future `fifo` top wrapper reuse these.
- No sub-module. The pointer-increment and next-state logic is inline: a registered block plus a combinational next-state block.
- A separate integration wrapper `fifo` instantiates `fifo_ctrl` and the register file. That wrapper is outside this block's scope.

## Test plan
- Reset, then hold idle for 3 cycles: `empty`=1, `full`=0, `count`=0, both addresses 0.
- Push 4 times with no pops (W=2): `w_addr` runs 1,2,3,0; `full`=1 after the 4th edge and `count`=4. A 5th push sets `ovf`=1, with `w_addr` staying 0 and `wr_en`=0.
- From full, pop 4 times: `r_addr` runs 1,2,3,0; `empty`=1 after the 4th edge and `count`=0. A 5th pop sets `udf`=1 and leaves `r_addr` unchanged.
- Fill to 2 entries, then assert `rd`+`wr` together for 5 cycles: `count` stays 2, both pointers wrap past 3 to 0, and no flags change.
- Empty FIFO with `rd`+`wr` in the same cycle: `count`=1, `empty`=0, `udf`=1. Full FIFO with `rd`+`wr`: `count`=4, `full`=1, `ovf`=0, and both pointers advance.
- Assert `reset_n`=0 mid-cycle with `count`=3: all outputs return to their reset values immediately, not at the next edge. `clr_err` clears `ovf` and `udf` on the next edge.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO sizing: default address width, depth and occupancy-count width.
// Imported by fifo_ctrl, the bench and the future fifo wrapper.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_W     = 2;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_W;
    localparam int unsigned FIFO_CNT_W = FIFO_W + 1;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, registered full/empty/count and sticky
// overflow/underflow flags in front of a 2^W-entry register file.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned W = FIFO_W
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr,
    input  logic         rd,
    input  logic         clr_err,
    output logic         wr_en,
    output logic [W-1:0] w_addr,
    output logic [W-1:0] r_addr,
    output logic         full,
    output logic         empty,
    output logic [W:0]   count,
    output logic         ovf,
    output logic         udf
);

    logic [W-1:0] w_addr_q, w_addr_d;
    logic [W-1:0] r_addr_q, r_addr_d;
    logic [W:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         ovf_q, ovf_d;
    logic         udf_q, udf_d;
    logic         push_s, pop_s;
    logic [W-1:0] w_addr_inc_s, r_addr_inc_s;

    // Request acceptance and next-state computation for pointers, status and error flags
    always_comb begin
        // A push into a full FIFO is accepted only when a pop frees the head slot this cycle
        push_s       = wr & (~full_q | rd);
        pop_s        = rd & ~empty_q;
        w_addr_inc_s = w_addr_q + W'(1'b1);
        r_addr_inc_s = r_addr_q + W'(1'b1);

        w_addr_d = w_addr_q;
        r_addr_d = r_addr_q;
        count_d  = count_q;
        full_d   = full_q;
        empty_d  = empty_q;

        if (push_s) begin
            w_addr_d = w_addr_inc_s;
        end else begin
            w_addr_d = w_addr_q;
        end

        if (pop_s) begin
            r_addr_d = r_addr_inc_s;
        end else begin
            r_addr_d = r_addr_q;
        end

        case ({push_s, pop_s})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (w_addr_inc_s == r_addr_q);
                count_d = count_q + (W+1)'(1'b1);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (r_addr_inc_s == w_addr_q);
                count_d = count_q - (W+1)'(1'b1);
            end
            default: begin
                full_d  = full_q;
                empty_d = empty_q;
                count_d = count_q;
            end
        endcase

        // A new error wins over a coincident clear
        ovf_d = (wr & full_q & ~rd) | (ovf_q & ~clr_err);
        udf_d = (rd & empty_q) | (udf_q & ~clr_err);
    end

    // State registers with asynchronous reset to the empty FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_addr_q <= '0;
            r_addr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            w_addr_q <= w_addr_d;
            r_addr_q <= r_addr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign wr_en  = push_s;
    assign w_addr = w_addr_q;
    assign r_addr = r_addr_q;
    assign count  = count_q;
    assign full   = full_q;
    assign empty  = empty_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (W=2): each task drives one scenario and checks
// hand-computed pointer, status and error-flag values.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    logic                  clk;
    logic                  reset_n;
    logic                  wr;
    logic                  rd;
    logic                  clr_err;
    logic                  wr_en;
    logic [FIFO_W-1:0]     w_addr;
    logic [FIFO_W-1:0]     r_addr;
    logic                  full;
    logic                  empty;
    logic [FIFO_CNT_W-1:0] count;
    logic                  ovf;
    logic                  udf;

    int errors = 0;
    int checks = 0;

    fifo_ctrl #(.W(FIFO_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr),
        .rd      (rd),
        .clr_err (clr_err),
        .wr_en   (wr_en),
        .w_addr  (w_addr),
        .r_addr  (r_addr),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr = 1'b1; rd = 1'b0; clr_err = 1'b0;
        #12;
        checks++;
        if (wr_en !== 1'b1) begin
            errors++; $display("FAIL reset_wr_en: got %b expected 1", wr_en);
        end
        wr = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({empty, full, count, w_addr, r_addr, ovf, udf} !== {1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got e=%b f=%b c=%0d wa=%0d ra=%0d o=%b u=%b expected e=1 f=0 c=0 wa=0 ra=0 o=0 u=0",
                     empty, full, count, w_addr, r_addr, ovf, udf);
        end
    endtask

    task automatic test_fill();
        logic [1:0] exp_wa;
        wr = 1'b1; rd = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_wa = 2'(i);
            checks++;
            if (w_addr !== exp_wa || count !== 3'(i) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_step%0d: got wa=%0d c=%0d e=%b expected wa=%0d c=%0d e=0",
                         i, w_addr, count, empty, exp_wa, i);
            end
        end
        checks++;
        if (full !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL fill_full: got f=%b wr_en=%b expected f=1 wr_en=0", full, wr_en);
        end
        tick();
        wr = 1'b0;
        checks++;
        if (ovf !== 1'b1 || w_addr !== 2'd0 || count !== 3'd4 || udf !== 1'b0) begin
            errors++;
            $display("FAIL fill_ovf: got o=%b wa=%0d c=%0d u=%b expected o=1 wa=0 c=4 u=0", ovf, w_addr, count, udf);
        end
    endtask

    task automatic test_drain();
        logic [1:0] exp_ra;
        rd = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_ra = 2'(i);
            checks++;
            if (r_addr !== exp_ra || count !== 3'(4 - i) || full !== 1'b0) begin
                errors++;
                $display("FAIL drain_step%0d: got ra=%0d c=%0d f=%b expected ra=%0d c=%0d f=0",
                         i, r_addr, count, full, exp_ra, 4 - i);
            end
        end
        checks++;
        if (empty !== 1'b1 || udf !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got e=%b u=%b expected e=1 u=0", empty, udf);
        end
        tick();
        rd = 1'b0;
        checks++;
        if (udf !== 1'b1 || r_addr !== 2'd0 || count !== 3'd0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL drain_udf: got u=%b ra=%0d c=%0d o=%b expected u=1 ra=0 c=0 o=1", udf, r_addr, count, ovf);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (ovf !== 1'b0 || udf !== 1'b0) begin
            errors++; $display("FAIL clr_err: got o=%b u=%b expected o=0 u=0", ovf, udf);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_wa;
        logic [1:0] exp_ra;
        wr = 1'b1; rd = 1'b0;
        tick(); tick();
        rd = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            exp_wa = 2'(2 + i);
            exp_ra = 2'(i);
            checks++;
            if (w_addr !== exp_wa || r_addr !== exp_ra || count !== 3'd2 ||
                {full, empty, ovf, udf} !== 4'b0000) begin
                errors++;
                $display("FAIL b2b_step%0d: got wa=%0d ra=%0d c=%0d f/e/o/u=%b expected wa=%0d ra=%0d c=2 f/e/o/u=0000",
                         i, w_addr, r_addr, count, {full, empty, ovf, udf}, exp_wa, exp_ra);
            end
        end
        wr = 1'b0; rd = 1'b1;
        tick(); tick();
        rd = 1'b0;
        checks++;
        if (empty !== 1'b1 || r_addr !== 2'd3 || w_addr !== 2'd3) begin
            errors++; $display("FAIL b2b_drain: got e=%b ra=%0d wa=%0d expected e=1 ra=3 wa=3", empty, r_addr, w_addr);
        end
    endtask

    task automatic test_simul_edges();
        wr = 1'b1; rd = 1'b1;
        tick();
        checks++;
        if (count !== 3'd1 || empty !== 1'b0 || udf !== 1'b1 || w_addr !== 2'd0 || r_addr !== 2'd3) begin
            errors++;
            $display("FAIL simul_empty: got c=%0d e=%b u=%b wa=%0d ra=%0d expected c=1 e=0 u=1 wa=0 ra=3",
                     count, empty, udf, w_addr, r_addr);
        end
        rd = 1'b0; clr_err = 1'b1;
        tick(); tick(); tick();
        clr_err = 1'b0;
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || udf !== 1'b0 || w_addr !== 2'd3) begin
            errors++;
            $display("FAIL simul_refill: got f=%b c=%0d u=%b wa=%0d expected f=1 c=4 u=0 wa=3", full, count, udf, w_addr);
        end
        rd = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b1) begin
            errors++; $display("FAIL simul_full_wr_en: got %b expected 1", wr_en);
        end
        tick();
        wr = 1'b0; rd = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || ovf !== 1'b0 || w_addr !== 2'd0 || r_addr !== 2'd0) begin
            errors++;
            $display("FAIL simul_full: got c=%0d f=%b o=%b wa=%0d ra=%0d expected c=4 f=1 o=0 wa=0 ra=0",
                     count, full, ovf, w_addr, r_addr);
        end
    endtask

    task automatic test_reset_mid();
        wr = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b1;
        tick();
        rd = 1'b0;
        checks++;
        if (count !== 3'd3 || ovf !== 1'b1 || r_addr !== 2'd1) begin
            errors++; $display("FAIL mid_setup: got c=%0d o=%b ra=%0d expected c=3 o=1 ra=1", count, ovf, r_addr);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({empty, full, count, w_addr, r_addr, ovf, udf} !== {1'b1, 1'b0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got e=%b f=%b c=%0d wa=%0d ra=%0d o=%b u=%b expected e=1 f=0 c=0 wa=0 ra=0 o=0 u=0",
                     empty, full, count, w_addr, r_addr, ovf, udf);
        end
        #2;
        reset_n = 1'b1;
        rd = 1'b1;
        tick();
        checks++;
        if (udf !== 1'b1 || r_addr !== 2'd0) begin
            errors++; $display("FAIL post_reset_udf: got u=%b ra=%0d expected u=1 ra=0", udf, r_addr);
        end
        clr_err = 1'b1;
        tick();
        checks++;
        if (udf !== 1'b1) begin
            errors++; $display("FAIL clr_vs_set: got u=%b expected 1", udf);
        end
        rd = 1'b0;
        tick();
        clr_err = 1'b0;
        checks++;
        if (udf !== 1'b0 || ovf !== 1'b0 || empty !== 1'b1) begin
            errors++; $display("FAIL clr_final: got u=%b o=%b e=%b expected u=0 o=0 e=1", udf, ovf, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simul_edges();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_ctrl
